// File: rtl/jstk_frame_ctrl_pkg.sv
// Shared definitions for the PmodJSTK frame sequencer: FSM encoding, command
// constants and the per-index transmit byte.
package jstk_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_GAP,
        ST_END,
        ST_ABORT
    } jstk_state_t;

    localparam logic [5:0] JSTK_CMD_LED     = 6'b100000;
    localparam int         JSTK_FRAME_BYTES = 5;

    // Only the first byte carries the LED command; the rest are dummy bytes.
    function automatic logic [7:0] jstk_tx_byte(input logic [2:0] idx, input logic [1:0] led);
        return (idx == 3'd0) ? {JSTK_CMD_LED, led} : 8'h00;
    endfunction

endpackage

// File: rtl/jstk_frame_unpack.sv
// Combinational unpacking of the five PmodJSTK reply bytes into X/Y and buttons.
module jstk_frame_unpack (
    input  logic [7:0] i_rx0,
    input  logic [7:0] i_rx1,
    input  logic [7:0] i_rx2,
    input  logic [7:0] i_rx3,
    input  logic [7:0] i_rx4,
    output logic [9:0] o_x_pos,
    output logic [9:0] o_y_pos,
    output logic [2:0] o_buttons
);

    logic w_unused_bits;

    assign o_x_pos   = {i_rx1[1:0], i_rx0};
    assign o_y_pos   = {i_rx3[1:0], i_rx2};
    assign o_buttons = i_rx4[2:0];

    // High bits of the reply bytes carry no information on this device.
    assign w_unused_bits = ^{i_rx1[7:2], i_rx3[7:2], i_rx4[7:3]};

endmodule

// File: rtl/jstk_frame_ctrl.sv
// PmodJSTK poll sequencer: issues a 5-byte frame to the SPI byte master every poll
// period and publishes X/Y/buttons atomically once a complete frame has arrived.
module jstk_frame_ctrl
    import jstk_frame_ctrl_pkg::*;
#(
    parameter int POLL_PERIOD_CYC = 3000,
    parameter int SS_SETUP_CYC    = 2,
    parameter int BYTE_GAP_CYC    = 2,
    parameter int TIMEOUT_CYC     = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] led_in,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out,
    output logic       spi_data_mode,
    output logic [7:0] spi_data_in,
    output logic       ss_n,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] buttons,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(POLL_PERIOD_CYC + SS_SETUP_CYC + BYTE_GAP_CYC + TIMEOUT_CYC + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t POLL_LAST  = cnt_t'((POLL_PERIOD_CYC > 0) ? POLL_PERIOD_CYC - 1 : 0);
    localparam cnt_t SETUP_LAST = cnt_t'((SS_SETUP_CYC    > 0) ? SS_SETUP_CYC    - 1 : 0);
    localparam cnt_t GAP_LAST   = cnt_t'((BYTE_GAP_CYC    > 0) ? BYTE_GAP_CYC    - 1 : 0);
    localparam cnt_t TO_LAST    = cnt_t'((TIMEOUT_CYC     > 0) ? TIMEOUT_CYC     - 1 : 0);
    localparam logic [2:0] LAST_IDX = 3'(JSTK_FRAME_BYTES - 1);

    jstk_state_t r_state;
    jstk_state_t w_state_next;
    cnt_t        r_cnt;
    logic [2:0]  r_idx;
    logic [1:0]  r_led;
    logic        r_busy_q;
    logic        r_busy_prev;
    logic        w_busy_fall;
    logic [7:0]  r_rx [JSTK_FRAME_BYTES];
    logic [JSTK_FRAME_BYTES-1:0] w_cap;
    logic [7:0]  r_tx;
    logic        r_ss_n;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [2:0]  r_btn;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic [9:0]  w_x;
    logic [9:0]  w_y;
    logic [2:0]  w_btn;

    assign w_busy_fall = r_busy_prev & ~r_busy_q;

    // Raw busy also gates the request so it drops the moment the master accepts.
    assign spi_data_mode = (r_state == ST_START) && !r_busy_q && !spi_busy;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_cnt >= POLL_LAST)  w_state_next = ST_SETUP;
            ST_SETUP: if (r_cnt >= SETUP_LAST) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_START;
            ST_START: begin
                if (r_busy_q)               w_state_next = ST_WAIT;
                else if (r_cnt >= TO_LAST)  w_state_next = ST_ABORT;
            end
            ST_WAIT: begin
                if (w_busy_fall)            w_state_next = (r_idx == LAST_IDX) ? ST_END : ST_GAP;
                else if (r_cnt >= TO_LAST)  w_state_next = ST_ABORT;
            end
            ST_GAP:   if (r_cnt >= GAP_LAST)   w_state_next = ST_LOAD;
            ST_END:   w_state_next = ST_IDLE;
            ST_ABORT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_led         <= '0;
            r_busy_q      <= 1'b0;
            r_busy_prev   <= 1'b0;
            r_tx          <= '0;
            r_ss_n        <= 1'b1;
            r_x           <= '0;
            r_y           <= '0;
            r_btn         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_busy_q      <= spi_busy;
            r_busy_prev   <= r_busy_q;
            r_state       <= w_state_next;
            r_frame_valid <= (r_state == ST_END);
            r_frame_err   <= (r_state == ST_ABORT);

            // One counter serves poll, setup, gap and timeout; it restarts per state.
            if (w_state_next != r_state)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + cnt_t'(1);

            case (r_state)
                ST_IDLE: if (w_state_next == ST_SETUP) begin
                    r_led  <= led_in;
                    r_ss_n <= 1'b0;
                end
                ST_LOAD: r_tx <= jstk_tx_byte(r_idx, r_led);
                ST_WAIT: if (w_busy_fall && r_idx != LAST_IDX) r_idx <= r_idx + 3'd1;
                ST_END: begin
                    r_ss_n <= 1'b1;
                    r_x    <= w_x;
                    r_y    <= w_y;
                    r_btn  <= w_btn;
                    r_idx  <= '0;
                end
                ST_ABORT: begin
                    r_ss_n <= 1'b1;
                    r_idx  <= '0;
                end
                default: ;
            endcase

            if (w_state_next == ST_ABORT)
                r_ss_n <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < JSTK_FRAME_BYTES; gi++) begin : g_cap
            assign w_cap[gi] = (r_state == ST_WAIT) && w_busy_fall && (r_idx == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < JSTK_FRAME_BYTES; i++) begin
            if (rst)
                r_rx[i] <= '0;
            else if (w_cap[i])
                r_rx[i] <= spi_data_out;
        end
    end

    jstk_frame_unpack u_unpack (
        .i_rx0     (r_rx[0]),
        .i_rx1     (r_rx[1]),
        .i_rx2     (r_rx[2]),
        .i_rx3     (r_rx[3]),
        .i_rx4     (r_rx[4]),
        .o_x_pos   (w_x),
        .o_y_pos   (w_y),
        .o_buttons (w_btn)
    );

    assign spi_data_in = r_tx;
    assign ss_n        = r_ss_n;
    assign x_pos       = r_x;
    assign y_pos       = r_y;
    assign buttons     = r_btn;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;

endmodule
